// File: rtl/mips_irq_ctl_pkg.sv
// Shared definitions for mips_irq_ctl: device-bus access codes, register offsets and address decode.
package mips_irq_ctl_pkg;

  localparam logic [3:0] DMEM_NOP = 4'd0;
  localparam logic [3:0] DMEM_SW  = 4'd5;
  localparam logic [3:0] DMEM_LW  = 4'd6;

  localparam logic [31:0] IRQ_ENABLE_OFS  = 32'h0000_0000;
  localparam logic [31:0] IRQ_PENDING_OFS = 32'h0000_0004;
  localparam logic [31:0] IRQ_MODE_OFS    = 32'h0000_0008;
  localparam logic [31:0] IRQ_ACTIVE_OFS  = 32'h0000_000C;
  localparam logic [31:0] IRQ_VECTOR_OFS  = 32'h0000_0010;

  localparam int IRQ_MAX_SRC = 16;

  typedef enum logic [2:0] {
    REG_NONE,
    REG_ENABLE,
    REG_PENDING,
    REG_MODE,
    REG_ACTIVE,
    REG_VECTOR
  } irq_reg_e;

  typedef struct packed {
    irq_reg_e   kind;
    logic [3:0] vidx;
  } irq_dec_t;

  // The vector window always spans IRQ_MAX_SRC words; the top masks indices >= N_SRC.
  function automatic irq_dec_t irq_decode(input logic [31:0] ofs);
    irq_dec_t   d;
    logic [29:0] word;
    word   = ofs[31:2];
    d.kind = REG_NONE;
    d.vidx = ofs[5:2] - IRQ_VECTOR_OFS[5:2];
    if (ofs[1:0] == 2'b00) begin
      if (word == IRQ_ENABLE_OFS[31:2])       d.kind = REG_ENABLE;
      else if (word == IRQ_PENDING_OFS[31:2]) d.kind = REG_PENDING;
      else if (word == IRQ_MODE_OFS[31:2])    d.kind = REG_MODE;
      else if (word == IRQ_ACTIVE_OFS[31:2])  d.kind = REG_ACTIVE;
      else if (word >= IRQ_VECTOR_OFS[31:2] &&
               word <  IRQ_VECTOR_OFS[31:2] + 30'(IRQ_MAX_SRC)) d.kind = REG_VECTOR;
    end
    return d;
  endfunction

endpackage

// File: rtl/irq_prio_enc.sv
// Combinational fixed-priority encoder: lowest set index wins, valid when any request is set.
module irq_prio_enc #(
  parameter int N = 4
) (
  input  logic [N-1:0] req_i,
  output logic         valid_o,
  output logic [3:0]   idx_o
);

  // NOTE: every output gets a default before the loop so no path leaves it unassigned (no latch).
  always_comb begin
    valid_o = 1'b0;
    idx_o   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req_i[i]) begin
        valid_o = 1'b1;
        idx_o   = 4'(i);
      end
    end
  end

endmodule

// File: rtl/mips_irq_ctl.sv
// Memory-mapped N_SRC-source interrupt controller for the mips789 device bus.
// Define IRQ_SYNC_EN to insert a two-flop synchroniser ahead of the sample flop on each src_i bit.
module mips_irq_ctl
  import mips_irq_ctl_pkg::*;
#(
  parameter int          N_SRC     = 4,
  parameter logic [31:0] BASE_ADDR = 32'h0000_3000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      din,
  input  logic [31:0]      addr,
  input  logic [3:0]       mem_ctl,
  output logic [31:0]      dout,
  input  logic [N_SRC-1:0] src_i,
  input  logic             irq_ack_i,
  output logic             irq_req_o,
  output logic [31:0]      irq_addr_o
);

  logic [N_SRC-1:0] src_in;

`ifdef IRQ_SYNC_EN
  localparam int SYNC_STAGES = 2;
  logic [N_SRC-1:0] sync1_q, sync2_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= src_i;
      sync2_q <= sync1_q;
    end
  end

  assign src_in = sync2_q;
`else
  localparam int SYNC_STAGES = 0;
  assign src_in = src_i;
`endif

  // arm_q fills with ones as real samples reach s_prev_q; until then no rising edge is recognised,
  // so a source already high at reset release must first be seen low.
  localparam int ARM_LEN = SYNC_STAGES + 2;

  logic [N_SRC-1:0]   s_q, s_prev_q;
  logic [ARM_LEN-1:0] arm_q;
  logic [N_SRC-1:0]   enable_q, enable_d;
  logic [N_SRC-1:0]   mode_q, mode_d;
  logic [N_SRC-1:0]   pend_q, pend_d;
  logic [31:0]        vec_q [N_SRC];
  logic [31:0]        vec_d [N_SRC];
  logic [3:0]         sel_q;
  logic               irq_req_q;
  logic [31:0]        irq_addr_q;
  logic [31:0]        dout_q;

  logic [31:0]      ofs;
  irq_dec_t         dec;
  logic             wr_en, rd_en;
  logic [N_SRC-1:0] rise, w1c, ack_clr, req_vec;
  logic             req_c;
  logic [3:0]       sel;
  logic [31:0]      sel_vec, rdata;

  assign ofs   = addr - BASE_ADDR;
  assign dec   = irq_decode(ofs);
  assign wr_en = (mem_ctl == DMEM_SW);
  assign rd_en = (mem_ctl == DMEM_LW);

  assign rise    = s_q & ~s_prev_q & {N_SRC{arm_q[ARM_LEN-1]}};
  assign req_vec = pend_q & enable_q;

  irq_prio_enc #(.N(N_SRC)) u_prio (
    .req_i  (req_vec),
    .valid_o(req_c),
    .idx_o  (sel)
  );

  always_comb begin
    enable_d = enable_q;
    mode_d   = mode_q;
    vec_d    = vec_q;
    w1c      = '0;
    ack_clr  = '0;
    if (wr_en) begin
      case (dec.kind)
        REG_ENABLE:  enable_d = din[N_SRC-1:0];
        REG_PENDING: w1c      = din[N_SRC-1:0];
        REG_MODE:    mode_d   = din[N_SRC-1:0];
        REG_VECTOR: begin
          for (int i = 0; i < N_SRC; i++) begin
            if (dec.vidx == 4'(i)) vec_d[i] = din;
          end
        end
        default: ;
      endcase
    end
    // An ack only means something while a request is presented, and only for the presented source.
    for (int i = 0; i < N_SRC; i++) begin
      if (irq_req_q && irq_ack_i && sel_q == 4'(i)) ack_clr[i] = 1'b1;
    end
    // Edge bits: set beats clear. Level bits: follow the sampled input.
    pend_d = (mode_q & ((pend_q & ~(w1c | ack_clr)) | rise)) | (~mode_q & s_q);
  end

  always_comb begin
    sel_vec = '0;
    for (int i = 0; i < N_SRC; i++) begin
      if (sel == 4'(i)) sel_vec = vec_q[i];
    end
  end

  always_comb begin
    rdata = '0;
    case (dec.kind)
      REG_ENABLE:  rdata[N_SRC-1:0] = enable_q;
      REG_PENDING: rdata[N_SRC-1:0] = pend_q;
      REG_MODE:    rdata[N_SRC-1:0] = mode_q;
      REG_ACTIVE:  rdata = {27'b0, req_c, sel};
      REG_VECTOR: begin
        for (int i = 0; i < N_SRC; i++) begin
          if (dec.vidx == 4'(i)) rdata = vec_q[i];
        end
      end
      default: ;
    endcase
  end

  // NOTE: non-blocking assignments here so every flop updates from pre-edge values.
  // NOTE: the vector array is a small flop array, not RAM, so it is reset like any other register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      s_q        <= '0;
      s_prev_q   <= '0;
      arm_q      <= '0;
      enable_q   <= '0;
      mode_q     <= '0;
      pend_q     <= '0;
      sel_q      <= '0;
      irq_req_q  <= 1'b0;
      irq_addr_q <= '0;
      dout_q     <= '0;
      for (int i = 0; i < N_SRC; i++) vec_q[i] <= '0;
    end else begin
      s_q        <= src_in;
      s_prev_q   <= s_q;
      arm_q      <= {arm_q[ARM_LEN-2:0], 1'b1};
      enable_q   <= enable_d;
      mode_q     <= mode_d;
      pend_q     <= pend_d;
      sel_q      <= sel;
      irq_req_q  <= req_c;
      irq_addr_q <= req_c ? sel_vec : 32'h0;
      dout_q     <= rd_en ? rdata : 32'h0;
      vec_q      <= vec_d;
    end
  end

  assign dout       = dout_q;
  assign irq_req_o  = irq_req_q;
  assign irq_addr_o = irq_addr_q;

endmodule

// File: tb/tb_mips_irq_ctl.sv
// Directed, table-driven bench for mips_irq_ctl (N_SRC=4 main instance, N_SRC=16 for the wide-map case).
module tb_mips_irq_ctl;
  import mips_irq_ctl_pkg::*;

  localparam logic [31:0] BASE = 32'h0000_3000;
`ifdef IRQ_SYNC_EN
  localparam int SYNC_LAT = 2;
`else
  localparam int SYNC_LAT = 0;
`endif

  typedef struct {
    logic        wr;
    logic [31:0] ofs;
    logic [31:0] wdata;
    logic [31:0] exp;
  } reg_vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] din, addr, dout, dout16, irq_addr, irq_addr16;
  logic [3:0]  mem_ctl;
  logic [3:0]  src;
  logic [15:0] src16;
  logic        ack, irq_req, irq_req16;

  int n_checks = 0;
  int n_pass   = 0;

  reg_vec_t tbl[$];

  always #5 clk = ~clk;

  mips_irq_ctl #(.N_SRC(4), .BASE_ADDR(BASE)) dut (
    .clk(clk), .rst(rst), .din(din), .addr(addr), .mem_ctl(mem_ctl), .dout(dout),
    .src_i(src), .irq_ack_i(ack), .irq_req_o(irq_req), .irq_addr_o(irq_addr)
  );

  mips_irq_ctl #(.N_SRC(16), .BASE_ADDR(BASE)) dut16 (
    .clk(clk), .rst(rst), .din(din), .addr(addr), .mem_ctl(mem_ctl), .dout(dout16),
    .src_i(src16), .irq_ack_i(ack), .irq_req_o(irq_req16), .irq_addr_o(irq_addr16)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [31:0] ofs, input logic [31:0] data);
    mem_ctl = DMEM_SW;
    addr    = BASE + ofs;
    din     = data;
    tick();
    mem_ctl = DMEM_NOP;
  endtask

  task automatic bus_read(input logic [31:0] ofs, output logic [31:0] d4, output logic [31:0] d16);
    mem_ctl = DMEM_LW;
    addr    = BASE + ofs;
    tick();
    d4      = dout;
    d16     = dout16;
    mem_ctl = DMEM_NOP;
  endtask

  task automatic read_check(input string name, input logic [31:0] ofs, input logic [31:0] exp);
    logic [31:0] d4, d16;
    bus_read(ofs, d4, d16);
    check(name, d4, exp);
  endtask

  task automatic pulse_src(input logic [3:0] m);
    src = m;
    tick();
    src = '0;
    repeat (1 + SYNC_LAT) tick();
  endtask

  task automatic ack_pulse();
    ack = 1'b1;
    tick();
    ack = 1'b0;
  endtask

  function automatic void add(input logic wr, input logic [31:0] ofs,
                              input logic [31:0] wdata, input logic [31:0] exp);
    reg_vec_t v;
    v.wr = wr; v.ofs = ofs; v.wdata = wdata; v.exp = exp;
    tbl.push_back(v);
  endfunction

  initial begin
    #500us;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "simulation time limit reached");
  end

  initial begin
    logic [31:0] d4, d16;

    rst = 1'b0; din = '0; addr = '0; mem_ctl = DMEM_NOP;
    src = '0; src16 = '0; ack = 1'b0;

    // Register map vectors: reset values, masking of bits >= N_SRC, read-back, vector window edge.
    add(0, 32'h00, 0, 32'h0);          add(0, 32'h04, 0, 32'h0);
    add(0, 32'h08, 0, 32'h0);          add(0, 32'h0C, 0, 32'h0);
    add(0, 32'h10, 0, 32'h0);          add(0, 32'h14, 0, 32'h0);
    add(0, 32'h18, 0, 32'h0);          add(0, 32'h1C, 0, 32'h0);
    add(1, 32'h00, 32'hFFFF_FFFF, 0);  add(0, 32'h00, 0, 32'h0000_000F);
    add(1, 32'h00, 32'h0, 0);          add(0, 32'h00, 0, 32'h0);
    add(1, 32'h08, 32'h0000_000F, 0);  add(0, 32'h08, 0, 32'h0000_000F);
    add(1, 32'h10, 32'h0000_00AA, 0);  add(1, 32'h14, 32'h0000_0100, 0);
    add(1, 32'h18, 32'h0000_0200, 0);  add(1, 32'h1C, 32'h0000_0300, 0);
    add(0, 32'h10, 0, 32'h0000_00AA);  add(0, 32'h14, 0, 32'h0000_0100);
    add(0, 32'h18, 0, 32'h0000_0200);  add(0, 32'h1C, 0, 32'h0000_0300);
    add(0, 32'h20, 0, 32'h0);

    // 1: reset state and register map
    repeat (3) tick();
    check("rst_irq_req", {31'b0, irq_req}, 32'h0);
    check("rst_irq_addr", irq_addr, 32'h0);
    check("rst_dout", dout, 32'h0);
    rst = 1'b1;
    tick();
    foreach (tbl[k]) begin
      if (tbl[k].wr) bus_write(tbl[k].ofs, tbl[k].wdata);
      else read_check($sformatf("reg_%02h", tbl[k].ofs), tbl[k].ofs, tbl[k].exp);
    end

    // 2: single edge source, exact latency, ack
    bus_write(IRQ_ENABLE_OFS, 32'h4);
    src = 4'h4;
    tick();
    src = '0;
    repeat (1 + SYNC_LAT) begin
      check("t2_req_early", {31'b0, irq_req}, 32'h0);
      tick();
    end
    read_check("t2_pending", IRQ_PENDING_OFS, 32'h4);
    check("t2_req", {31'b0, irq_req}, 32'h1);
    check("t2_addr", irq_addr, 32'h200);
    ack_pulse();
    check("t2_req_ack_edge", {31'b0, irq_req}, 32'h1);
    tick();
    check("t2_req_after_ack", {31'b0, irq_req}, 32'h0);
    check("t2_addr_after_ack", irq_addr, 32'h0);
    read_check("t2_pending_clr", IRQ_PENDING_OFS, 32'h0);

    // 3: priority, ack walks to the next source, higher priority preempts
    bus_write(IRQ_ENABLE_OFS, 32'hA);
    pulse_src(4'hA);
    check("t3_req_early", {31'b0, irq_req}, 32'h0);
    tick();
    check("t3_req", {31'b0, irq_req}, 32'h1);
    check("t3_addr_src1", irq_addr, 32'h100);
    ack_pulse();
    check("t3_addr_ack_edge", irq_addr, 32'h100);
    tick();
    check("t3_addr_src3", irq_addr, 32'h300);
    pulse_src(4'h2);
    check("t3_addr_before_preempt", irq_addr, 32'h300);
    tick();
    check("t3_addr_preempt", irq_addr, 32'h100);
    ack_pulse();
    tick();
    check("t3_addr_back_src3", irq_addr, 32'h300);
    ack_pulse();
    tick();
    check("t3_req_done", {31'b0, irq_req}, 32'h0);
    check("t3_addr_done", irq_addr, 32'h0);

    // 4: enable gating, ignored ack, W1C, set wins over clear
    bus_write(IRQ_ENABLE_OFS, 32'h0);
    pulse_src(4'h1);
    tick();
    check("t4_req_disabled", {31'b0, irq_req}, 32'h0);
    read_check("t4_pending_disabled", IRQ_PENDING_OFS, 32'h1);
    bus_write(IRQ_ENABLE_OFS, 32'h1);
    tick();
    check("t4_req_reenable", {31'b0, irq_req}, 32'h1);
    check("t4_addr_reenable", irq_addr, 32'hAA);
    bus_write(IRQ_ENABLE_OFS, 32'h0);
    tick();
    check("t4_req_masked", {31'b0, irq_req}, 32'h0);
    read_check("t4_pending_kept", IRQ_PENDING_OFS, 32'h1);
    ack_pulse();
    read_check("t4_pending_ack_ignored", IRQ_PENDING_OFS, 32'h1);
    bus_write(IRQ_PENDING_OFS, 32'h1);
    read_check("t4_pending_w1c", IRQ_PENDING_OFS, 32'h0);
    src = 4'h1;
    tick();
    repeat (SYNC_LAT) tick();
    bus_write(IRQ_PENDING_OFS, 32'h1);
    src = '0;
    read_check("t4_set_wins", IRQ_PENDING_OFS, 32'h1);
    bus_write(IRQ_PENDING_OFS, 32'h1);
    read_check("t4_pending_final", IRQ_PENDING_OFS, 32'h0);

    // 5: level mode ignores W1C and ack, follows the input
    bus_write(IRQ_MODE_OFS, 32'hD);
    bus_write(IRQ_ENABLE_OFS, 32'h2);
    src = 4'h2;
    tick();
    repeat (1 + SYNC_LAT) tick();
    check("t5_req_early", {31'b0, irq_req}, 32'h0);
    tick();
    check("t5_req", {31'b0, irq_req}, 32'h1);
    check("t5_addr", irq_addr, 32'h100);
    bus_write(IRQ_PENDING_OFS, 32'h2);
    read_check("t5_w1c_ignored", IRQ_PENDING_OFS, 32'h2);
    ack_pulse();
    tick();
    check("t5_ack_ignored", {31'b0, irq_req}, 32'h1);
    src = '0;
    repeat (2 + SYNC_LAT) begin
      tick();
      check("t5_req_hold", {31'b0, irq_req}, 32'h1);
    end
    tick();
    check("t5_req_fall", {31'b0, irq_req}, 32'h0);

    // 7: reset mid-operation; a level already high at release is not an edge
    bus_write(IRQ_MODE_OFS, 32'hF);
    bus_write(IRQ_ENABLE_OFS, 32'hF);
    src = 4'h4;
    tick();
    repeat (1 + SYNC_LAT) tick();
    tick();
    check("t7_req_before_rst", {31'b0, irq_req}, 32'h1);
    check("t7_addr_before_rst", irq_addr, 32'h200);
    rst = 1'b0;
    mem_ctl = DMEM_LW;
    addr = BASE + IRQ_ACTIVE_OFS;
    tick();
    check("t7_rst_req", {31'b0, irq_req}, 32'h0);
    check("t7_rst_addr", irq_addr, 32'h0);
    check("t7_rst_dout", dout, 32'h0);
    rst = 1'b1;
    mem_ctl = DMEM_SW;
    addr = BASE + IRQ_MODE_OFS;
    din = 32'hF;
    tick();
    mem_ctl = DMEM_NOP;
    bus_write(IRQ_ENABLE_OFS, 32'hF);
    repeat (3 + SYNC_LAT) tick();
    check("t7_no_edge_req", {31'b0, irq_req}, 32'h0);
    read_check("t7_no_edge_pending", IRQ_PENDING_OFS, 32'h0);
    read_check("t7_vector_reset", 32'h18, 32'h0);
    src = '0;
    repeat (2 + SYNC_LAT) tick();
    pulse_src(4'h4);
    tick();
    check("t7_new_edge_req", {31'b0, irq_req}, 32'h1);

    // 6: 16-source map, ACTIVE encoding and vector window boundary
    src16 = 16'h8000;
    bus_write(IRQ_ENABLE_OFS, 32'h0000_8000);
    repeat (1 + SYNC_LAT) tick();
    bus_read(IRQ_ACTIVE_OFS, d4, d16);
    check("t6_active16", d16, 32'h0000_001F);
    check("t6_active4_none", d4, 32'h0);
    check("t6_req16", {31'b0, irq_req16}, 32'h1);
    check("t6_addr16", irq_addr16, 32'h0);
    bus_write(32'h4C, 32'h0000_0F00);
    bus_read(32'h4C, d4, d16);
    check("t6_vec15_16", d16, 32'h0000_0F00);
    check("t6_vec15_4", d4, 32'h0);
    check("t6_irq_addr16", irq_addr16, 32'h0000_0F00);
    bus_read(32'h50, d4, d16);
    check("t6_vec16_16", d16, 32'h0);
    read_check("t6_vec4_4", 32'h20, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
